// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: mode encodings and the shared immediate-extension function
package imm_ext_pkg;
  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);
  typedef enum logic [1:0] {
    IMM_SEXT  = 2'b00,
    IMM_ZEXT  = 2'b01,
    IMM_SHIFT = 2'b10,
    IMM_UPPER = 2'b11
  } mode_t;
  function automatic logic [MAX_W-1:0] imm_extend(
    input logic [MAX_W-1:0] imm,
    input mode_t            mode,
    input int unsigned      shamt,
    input int unsigned      in_w,
    input int unsigned      out_w
  );
    logic [MAX_W-1:0] mask, zx, sx;
    mask = ~({MAX_W{1'b1}} << in_w);
    zx   = imm & mask;
    sx   = imm[IDX_W'(in_w - 1)] ? (zx | ~mask) : zx;
    return mode == IMM_SEXT  ? sx :
           mode == IMM_ZEXT  ? zx :
           mode == IMM_UPPER ? zx << (out_w - in_w) :
           shamt >= out_w    ? '0 : sx << shamt;
  endfunction
endpackage

// File: rtl/imm_skid_buf.sv
// imm_skid_buf: two-register valid/ready skid buffer with registered in_ready
module imm_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] data_o
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  assign in_ready_o = !skid_valid;
  // Output register refills from skid first, else from input; held output diverts input to skid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      data_o      <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
    end else if (!out_valid_o || out_ready_i) begin
      out_valid_o <= skid_valid || in_valid_i;
      if (skid_valid) data_o <= skid_data;
      else if (in_valid_i) data_o <= data_i;
      skid_valid <= 1'b0;
    end else if (in_valid_i && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= data_i;
    end
  end
endmodule

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: pipelined immediate extender; IMM_OVF_DETECT_EN adds the shift-overflow flag ovf_o
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int SH_W  = $clog2(OUT_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  input  logic [SH_W-1:0]  shamt_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] imm_o
`ifdef IMM_OVF_DETECT_EN
  ,output logic            ovf_o
`endif
);
  logic [OUT_W-1:0] res;
  // Extend the incoming field according to the requested mode
  always_comb res = OUT_W'(imm_extend(MAX_W'(imm_i), mode_t'(mode_i), 32'(shamt_i), IN_W, OUT_W));
`ifdef IMM_OVF_DETECT_EN
  logic [OUT_W-1:0] sx;
  logic             ovf;
  // Overflow when shifting back arithmetically fails to recover the sign-extended input
  always_comb begin
    sx  = OUT_W'(imm_extend(MAX_W'(imm_i), IMM_SEXT, 0, IN_W, OUT_W));
    ovf = mode_t'(mode_i) == IMM_SHIFT &&
          (32'(shamt_i) >= OUT_W ? |imm_i : OUT_W'($signed(res) >>> shamt_i) != sx);
  end
  imm_skid_buf #(.W(OUT_W + 1)) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      ({ovf, res}),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      ({ovf_o, imm_o})
  );
`else
  imm_skid_buf #(.W(OUT_W)) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (res),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (imm_o)
  );
`endif
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed vectors checked against an arithmetic model and a FIFO scoreboard
module tb_imm_extend_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  imm = '0;
  logic [1:0]  mode = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] imm_o;
  logic        ovf;
  int          vectors = 0;
  int          miscompares = 0;
  logic        mix = 1'b0;
  int          pat = 0;

  typedef struct {logic [15:0] v; logic o;} res_t;
  res_t        q[$];
  logic [15:0] seen[$];

  always #5 clk = ~clk;

  imm_extend_unit #(.IN_W(8), .OUT_W(16), .SH_W(5)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .imm_i       (imm),
    .mode_i      (mode),
    .shamt_i     (shamt),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .imm_o       (imm_o)
`ifdef IMM_OVF_DETECT_EN
    ,.ovf_o      (ovf)
`endif
  );
`ifndef IMM_OVF_DETECT_EN
  assign ovf = 1'b0;
`endif

  function automatic res_t model(logic [7:0] i, logic [1:0] m, int sh);
    res_t   r;
    longint s, p;
    s   = longint'($signed(i));
    r.o = 1'b0;
    case (m)
      2'd0: r.v = 16'(s);
      2'd1: r.v = {8'h00, i};
      2'd3: r.v = {i, 8'h00};
      default: begin
        if (sh >= 16) begin
          r.v = 16'h0000;
          r.o = (i != 8'h00);
        end else begin
          p   = s * (longint'(1) << sh);
          r.v = 16'(p);
          r.o = (p > 32767) || (p < -32768);
        end
      end
    endcase
`ifndef IMM_OVF_DETECT_EN
    r.o = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic        held = 1'b0;
  logic [15:0] held_v = '0;
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_imm", 32'(imm_o), 32'd0);
      held = 1'b0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (held) chk("hold_stable", 32'(imm_o), 32'(held_v));
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("data", 32'(imm_o), 32'(e.v));
`ifdef IMM_OVF_DETECT_EN
        chk("ovf", 32'(ovf), 32'(e.o));
`endif
        seen.push_back(imm_o);
      end
      if (in_valid && in_ready) q.push_back(model(imm, mode, int'(shamt)));
      held   = out_valid && !out_ready;
      held_v = imm_o;
    end
  end

  always @(posedge clk) begin
    if (mix) begin
      #2 out_ready = (pat % 3) != 0;
      pat++;
    end
  end

  task automatic send(logic [7:0] i, logic [1:0] m, logic [4:0] s);
    int   n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    imm = i;
    mode = m;
    shamt = s;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic single(logic [7:0] i, logic [1:0] m, logic [4:0] s, logic [15:0] ev, logic eo);
    send(i, m, s);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lit_imm", 32'(imm_o), 32'(ev));
`ifdef IMM_OVF_DETECT_EN
    chk("lit_ovf", 32'(ovf), 32'(eo));
`else
    chk("lit_ovf_absent", 32'(ovf | eo & 1'b0), 32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_bp [3] = '{16'h0001, 16'h0002, 16'h0003};
    time t0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    single(8'h80, 2'd0, 5'd0,  16'hFF80, 1'b0);
    single(8'h80, 2'd1, 5'd0,  16'h0080, 1'b0);
    single(8'hA5, 2'd3, 5'd0,  16'hA500, 1'b0);
    single(8'hFE, 2'd2, 5'd1,  16'hFFFC, 1'b0);
    single(8'h7F, 2'd0, 5'd0,  16'h007F, 1'b0);
    single(8'hFF, 2'd1, 5'd0,  16'h00FF, 1'b0);
    single(8'h7F, 2'd2, 5'd9,  16'hFE00, 1'b1);
    single(8'h03, 2'd2, 5'd4,  16'h0030, 1'b0);
    single(8'h01, 2'd2, 5'd16, 16'h0000, 1'b1);
    single(8'h80, 2'd2, 5'd15, 16'h0000, 1'b1);
    single(8'h80, 2'd2, 5'd0,  16'hFF80, 1'b0);
    single(8'h00, 2'd2, 5'd31, 16'h0000, 1'b0);
    // backpressure: two accepted, third held until the consumer releases
    seen.delete();
    out_ready = 1'b0;
    send(8'h01, 2'd0, 5'd0);
    send(8'h02, 2'd0, 5'd0);
    in_valid = 1'b1;
    imm = 8'h03;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h03, 2'd0, 5'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_count", 32'(seen.size()), 32'd3);
    for (int i = 0; i < seen.size() && i < 3; i++) chk("bp_order", 32'(seen[i]), 32'(exp_bp[i]));
    // streaming: one accept per cycle
    t0 = $time;
    for (int k = 0; k < 16; k++) send(8'(k * 17), 2'd0, 5'd0);
    chk("stream_cycles", 32'(($time - t0) / 10), 32'd16);
    repeat (3) @(posedge clk);
    #1;
    // reset with the skid buffer full
    seen.delete();
    out_ready = 1'b0;
    send(8'h11, 2'd1, 5'd0);
    send(8'h22, 2'd1, 5'd0);
    @(negedge clk);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_stale", 32'(seen.size()), 32'd0);
    // mixed modes under a stalling consumer
    mix = 1'b1;
    for (int k = 0; k < 30; k++) send(8'(k * 37 + 5), 2'(k % 4), 5'(k % 18));
    mix = 1'b0;
    @(posedge clk);
    #3 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
- Parametrised, pipelined successor to the 16-bit combinational sign extender.
- Extends an IN_W-bit immediate field to OUT_W bits in one of four modes: sign, zero, sign-and-shift (branch/jump offsets), or upper-load.
- Output is registered behind a valid/ready handshake with a one-entry skid buffer, so it can sit between decode and execute once the datapath is pipelined.

Parameters:
- IN_W, 8, width of the immediate input field; must satisfy 1 <= IN_W <= OUT_W.
- OUT_W, 16, width of the extended result.
- SH_W, $clog2(OUT_W), width of the shift-amount input.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  unit can accept a request this cycle.
- imm_i  input  IN_W  raw immediate field.
- mode_i  input  2  extension mode (encodings in package).
- shamt_i  input  SH_W  left-shift amount; used in SHIFT mode only.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- imm_o  output  OUT_W  extended result.
- ovf_o  output  1  shift overflow flag; present only with IMM_OVF_DETECT_EN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - out_valid_o=0, imm_o=0, ovf_o=0.
  - Skid buffer is empty with data cleared.
  - in_ready_o=1 from the first cycle after reset deassertion.
- Modes:
  - SEXT (00): replicate imm_i[IN_W-1] into the upper OUT_W-IN_W bits.
  - ZEXT (01): zero-fill the upper bits.
  - SHIFT (10): sign-extend, then shift left by shamt_i, truncated to OUT_W; shamt_i >= OUT_W gives 0.
  - UPPER (11): imm_i placed in bits [OUT_W-1:OUT_W-IN_W], lower bits zero.
  - When IN_W == OUT_W, SEXT, ZEXT and UPPER all pass imm_i through unchanged.
- Transfer rules:
  - An input transfer happens when in_valid_i && in_ready_o.
  - An output transfer happens when out_valid_o && out_ready_i.
  - in_ready_o = !skid_valid. It is a registered signal with no combinational path from out_ready_i.
- Latency: exactly 1 cycle from an accepted input to out_valid_o when the output register is empty or draining.
- Accepted input with output register empty, or being drained this cycle: the computed result loads the output register.
- Accepted input with output held (out_valid_o=1, out_ready_i=0): the result loads the skid buffer; in_ready_o drops the next cycle.
- Output drained while the skid buffer is full: skid moves to the output register and the skid buffer empties.
  - If a new input arrives in the same cycle, it is not accepted, because in_ready_o=0.
- Ordering: strict FIFO order; no result is ever dropped or duplicated.
- Held output: while out_valid_o=1 and out_ready_i=0, imm_o and ovf_o remain stable.
- Mid-operation reset: all pending results are discarded immediately, with no output transfer in that cycle.
- in_valid_i while in_ready_o=0: ignored. The producer must hold its data.

Optional Feature:
- Macro: IMM_OVF_DETECT_EN.
- Defined:
  - ovf_o exists and is pipelined alongside imm_o.
  - In SHIFT mode, ovf_o=1 when the arithmetic right shift of the result by shamt_i differs from the sign-extended input.
  - ovf_o=1 for shamt_i >= OUT_W with nonzero imm_i.
  - ovf_o=0 in all other modes.
- Undefined: the ovf_o port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package imm_ext_pkg holds:
  - mode encodings IMM_SEXT=2'b00, IMM_ZEXT=2'b01, IMM_SHIFT=2'b10, IMM_UPPER=2'b11;
  - the mode_t typedef;
  - a pure function computing the extended value from imm, mode and shamt, so that decode can reuse it.
- One sub-module is natural: imm_skid_buf, a generic width-parametrised 2-register valid/ready skid buffer. The top level computes the result and feeds it in.

Test Plan (IN_W=8, OUT_W=16):
- Mode coverage, out_ready_i=1: imm 0x80 in SEXT -> 0xFF80; ZEXT -> 0x0080; UPPER 0xA5 -> 0xA500; SHIFT 0xFE, shamt 1 -> 0xFFFC. Each appears 1 cycle after acceptance.
- Backpressure: hold out_ready_i=0 and offer 3 requests (0x01, 0x02, 0x03, SEXT) -> 2 accepted, in_ready_o=0 while the third is held; release -> 0x0001, 0x0002, 0x0003 emerge in order, with no gaps after the skid drains.
- Streaming: continuous valid with out_ready_i=1 for 16 SEXT requests -> one result per cycle, in_ready_o never drops.
- Reset mid-operation: skid buffer full, assert rst_ni low -> same-cycle out_valid_o=0 and in_ready_o=1 after release; no stale result appears.
- Overflow (IMM_OVF_DETECT_EN): SHIFT 0x7F, shamt 9 -> imm_o=0xFE00, ovf_o=1. SHIFT 0x03, shamt 4 -> 0x0030, ovf_o=0. SHIFT 0x01, shamt 16 -> 0x0000, ovf_o=1.
- Edge shift: SHIFT 0x80, shamt 15 -> 0x0000 with ovf_o=1; shamt 0 -> 0xFF80 with ovf_o=0.
